// File: rtl/chan_mux_rr.sv
// N-channel registered multiplexer with valid/ready handshakes, selectable
// between an externally driven channel index and round-robin arbitration.
module chan_mux_rr #(
    parameter int WIDTH = 4,
    parameter int N_CH  = 4,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_ch
);

    // Returns {found, index} of the first valid channel after ptr, wrapping through ptr.
    function automatic logic [SEL_W:0] rr_search(input logic [N_CH-1:0]  valid,
                                                 input logic [SEL_W-1:0] ptr);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = SEL_W'((int'(ptr) + k) % N_CH);
            if (!res[SEL_W] && valid[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0]     out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]     rr_ptr_q,    rr_ptr_d;

    logic                 slot_free_s;
    logic                 cand_valid_s;
    logic [SEL_W-1:0]     cand_idx_s;
    logic                 grant_s;
    logic [WIDTH-1:0]     cand_data_s;
    logic [N_CH-1:0]      in_ready_s;
    logic [SEL_W:0]       rr_res_s;

    // Candidate selection: fixed index or round-robin search after the last grant.
    always_comb begin
        cand_valid_s = 1'b0;
        cand_idx_s   = '0;
        rr_res_s     = rr_search(in_valid, rr_ptr_q);
        if (mode == 1'b0) begin
            if (int'(sel) < N_CH) begin
                cand_valid_s = in_valid[sel];
                cand_idx_s   = sel;
            end else begin
                cand_valid_s = 1'b0;
            end
        end else begin
            cand_valid_s = rr_res_s[SEL_W];
            cand_idx_s   = rr_res_s[SEL_W-1:0];
        end
    end

    // Grant generation; no channel is accepted while reset is asserted.
    always_comb begin
        slot_free_s = !out_valid_q || out_ready;
        grant_s     = rst_n && slot_free_s && cand_valid_s;
        in_ready_s  = '0;
        cand_data_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cand_idx_s == SEL_W'(i)) begin
                in_ready_s[i] = grant_s;
                cand_data_s   = in_data[i*WIDTH +: WIDTH];
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    // Output register next state: load on grant, drain on consume, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_s) begin
            out_valid_d = 1'b1;
            out_data_d  = cand_data_s;
            out_ch_d    = cand_idx_s;
            rr_ptr_d    = cand_idx_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; rr_ptr resets to the last channel so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= SEL_W'(N_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Directed, table-driven bench for chan_mux_rr (WIDTH=4, N_CH=4).
module tb_chan_mux_rr;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;

    int checks   = 0;
    int failures = 0;

    chan_mux_rr #(.WIDTH(4), .N_CH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        mode;
        logic [1:0]  sel;
        logic [15:0] data;
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  exp_ir;
        logic        exp_ov;
        logic [3:0]  exp_od;
        logic [1:0]  exp_och;
    } vec_t;

    localparam int NV = 22;
    localparam logic [15:0] D0 = 16'h4321;
    localparam logic [15:0] DA = 16'h4A21;
    localparam logic [15:0] D5 = 16'h4351;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        // mode, sel, data, valid, ordy | in_ready, out_valid, out_data, out_ch (after edge)
        vecs[0]  = '{1'b0, 2'd0, D0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0}; // idle
        vecs[1]  = '{1'b0, 2'd2, DA, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2}; // fixed ch2
        vecs[2]  = '{1'b0, 2'd1, DA, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'hA, 2'd2}; // sel1 not valid
        vecs[3]  = '{1'b1, 2'd0, D0, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3}; // RR after fixed ch2
        vecs[4]  = '{1'b1, 2'd0, D0, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
        vecs[5]  = '{1'b1, 2'd0, D0, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
        vecs[6]  = '{1'b1, 2'd0, D0, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2};
        vecs[7]  = '{1'b1, 2'd0, D0, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3};
        vecs[8]  = '{1'b1, 2'd0, D0, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
        vecs[9]  = '{1'b1, 2'd0, D0, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1}; // single requester
        vecs[10] = '{1'b1, 2'd0, D0, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0}; // wrap to ch0
        vecs[11] = '{1'b1, 2'd0, D0, 4'b1001, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3}; // skip to ch3
        vecs[12] = '{1'b1, 2'd0, D0, 4'b1001, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0}; // wrap to ch0
        vecs[13] = '{1'b1, 2'd0, D5, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1}; // load 5
        vecs[14] = '{1'b1, 2'd0, D5, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd1}; // backpressure
        vecs[15] = '{1'b1, 2'd0, D5, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd1};
        vecs[16] = '{1'b1, 2'd0, D5, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd1};
        vecs[17] = '{1'b1, 2'd0, D5, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2}; // no bubble
        vecs[18] = '{1'b1, 2'd0, D5, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'h3, 2'd2}; // drain
        vecs[19] = '{1'b0, 2'd0, D0, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0}; // fixed ch0
        vecs[20] = '{1'b0, 2'd3, D0, 4'b1000, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd0}; // fixed stalled
        vecs[21] = '{1'b0, 2'd3, D0, 4'b1000, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3}; // fixed ch3

        // Reset with arbitrary inputs
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = 2'($urandom_range(0, 3));
        in_data   = 16'($urandom);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {15'd0, out_valid}, 16'd0);
        chk("reset_out_data",  {12'd0, out_data},  16'd0);
        chk("reset_out_ch",    {14'd0, out_ch},    16'd0);
        chk("reset_in_ready",  {12'd0, in_ready},  16'd0);
        @(negedge clk);
        in_valid = 4'b0000;
        rst_n    = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            mode      = vecs[i].mode;
            sel       = vecs[i].sel;
            in_data   = vecs[i].data;
            in_valid  = vecs[i].valid;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), {12'd0, in_ready}, {12'd0, vecs[i].exp_ir});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), {15'd0, out_valid}, {15'd0, vecs[i].exp_ov});
            chk($sformatf("v%0d_out_data", i),  {12'd0, out_data},  {12'd0, vecs[i].exp_od});
            chk($sformatf("v%0d_out_ch", i),    {14'd0, out_ch},    {14'd0, vecs[i].exp_och});
        end

        // Reset while a word is held: output drops without waiting for a clock
        @(negedge clk);
        mode      = 1'b1;
        in_data   = D0;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        chk("mid_pre_out_valid", {15'd0, out_valid}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("mid_rst_out_data",  {12'd0, out_data},  16'd0);
        chk("mid_rst_in_ready",  {12'd0, in_ready},  16'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", {12'd0, in_ready}, 16'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", {15'd0, out_valid}, 16'd1);
        chk("post_rst_out_data",  {12'd0, out_data},  16'h1);
        chk("post_rst_out_ch",    {14'd0, out_ch},    16'd0);
        @(negedge clk);
        #1;
        chk("post_rst_next_grant", {12'd0, in_ready}, 16'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chan_mux_rr.md
Name: chan_mux_rr

Overview:
- Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake. Successor to the lab's 2:1 4-bit combinational mux.
- Two selection modes:
  - fixed: external select, as in the 2:1 mux.
  - round-robin: automatic fair arbitration across channels.
- One-entry output register. Sits between several producer channels and a single consumer stage.

Parameters:
- WIDTH, 4, data width of each channel and of the output.
- N_CH, 4, number of input channels, ≥2.
- SEL_W, $clog2(N_CH), select/channel-index width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index in fixed mode; ignored in round-robin.
- in_data  input  N_CH*WIDTH  flattened channel data; channel i at [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel data valid.
- in_ready  output  N_CH  per-channel accept; at most one bit high per cycle.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds an untaken word.
- out_ready  input  1  consumer accepts out_data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_ch=0.
  - Internal rr_ptr (last granted channel) = N_CH-1, so channel 0 has first priority.
- slot_free = !out_valid || out_ready. This is a combinational pass-through of out_ready, so full throughput is sustained.
- Candidate selection (combinational):
  - mode=0: candidate = sel, only if sel < N_CH and in_valid[sel]=1.
    - sel ≥ N_CH → no candidate; all in_ready=0.
  - mode=1: search in_valid starting at rr_ptr+1 mod N_CH, wrapping through rr_ptr. The first set bit is the candidate.
    - No bit set → no candidate.
- Grant: in_ready[c]=1 iff slot_free and candidate c exists. All other in_ready bits are 0.
  - in_ready never depends on in_valid of non-candidate channels.
- Transfer on rising edge with grant (in_valid[c] && in_ready[c]):
  - out_data <= channel c data; out_ch <= c; out_valid <= 1; rr_ptr <= c.
  - rr_ptr updates in both modes.
- No grant and out_ready=1 → out_valid <= 0. out_data/out_ch hold their last values.
- Backpressure: out_valid=1 and out_ready=0 → out_data, out_ch, out_valid stable; all in_ready=0.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 word/cycle while out_ready=1.
- Simultaneous out_ready=1 and new grant: the old word is consumed and the new word is loaded on the same edge, with no bubble.
- Mode switch:
  - Takes effect on the same cycle's selection.
  - rr_ptr is preserved across switches, so round-robin resumes after the last granted channel, including grants made in fixed mode.
- Wrap-around: rr_ptr=N_CH-1 → search starts at channel 0.
- Single requester in round-robin gets a grant every cycle; there are no forced idle cycles.
- Reset mid-transfer: an in-flight output word is discarded, out_valid drops immediately, and arbitration restarts with channel 0 priority.
- Producers must hold in_data/in_valid stable until accepted; the block does not check this.

Test Plan:
- Reset/idle: rst_n=0 with random inputs → out_valid=0, out_data=0, out_ch=0, in_ready=0000; release, all in_valid=0 → outputs unchanged.
- Fixed mode: mode=0, sel=2, in_data ch2=4'hA, in_valid=4'b0100, out_ready=1 → in_ready=4'b0100; next cycle out_data=4'hA, out_ch=2, out_valid=1. Change to sel=1 with in_valid[1]=0 → no grant, out_valid=0 the following cycle.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1, data ch i = i+1 → out_ch sequence 0,1,2,3,0,… and out_data 1,2,3,4,1,…, one word per cycle.
- Skip and wrap: mode=1, rr_ptr=1 (last grant ch1), in_valid=4'b0001 → grant ch0 (wrap); then in_valid=4'b1001 → grant ch3, then ch0.
- Backpressure: out_valid=1 with out_data=4'h5, out_ready=0 for 3 cycles, in_valid=4'b1111 → out_data stays 4'h5, in_ready=0000; out_ready=1 → the next RR channel loads with no bubble.
- Mode switch and reset mid-operation: fixed mode grants ch2, then mode=1 with all valid → first RR grant is ch3. Assert rst_n=0 while out_valid=1 → out_valid=0 immediately; after release, first RR grant is ch0.
